// File: rtl/attr_palette_lookup.sv
// Writable NES attribute-table RAM with mirroring-aware, 2-cycle pipelined palette lookup.
// Define ATTR_BYPASS_EN to forward same-address writes into in-flight lookups.
module attr_palette_lookup #(
  parameter int unsigned NUM_NT    = 2,
  parameter logic [7:0]  CLEAR_VAL = 8'h00,
  localparam int unsigned AW       = $clog2(64 * NUM_NT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    mirror,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [1:0]    req_nt,
  input  logic [4:0]    req_col,
  input  logic [4:0]    req_row,
  output logic          pal_valid,
  output logic [1:0]    pal,
  output logic [7:0]    pal_byte,
  output logic          busy
);

  localparam int unsigned DEPTH = 64 * NUM_NT;

  typedef enum logic [0:0] {StClear, StReady} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   clr_cnt_q, clr_cnt_d;
  logic [7:0]      mem [DEPTH];
  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [7:0]      mem_wdata;
  logic            wr_ok;

  logic [1:0]      phys;
  logic [AW-1:0]   rd_addr;
  logic [2:0]      sh;
  logic            oor;
  logic            accept;

  logic            v1_q;
  logic [2:0]      sh1_q;
  logic            oor1_q;
  logic [7:0]      rd_byte_q;
  logic [7:0]      byte1;
  logic [1:0]      pal_sel;

  logic            pal_valid_q;
  logic [1:0]      pal_q;
  logic [7:0]      pal_byte_q;

  logic            unused_bits;
  assign unused_bits = req_col[0];

  assign busy      = (state_q == StClear);
  assign req_ready = ~busy;
  assign wr_ok     = (state_q == StReady) && wr_en && !rst;
  assign accept    = req_valid && req_ready;

  // Clear FSM owns the single write port while busy.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
    unique case (state_q)
      StClear: begin
        mem_we    = 1'b1;
        mem_waddr = clr_cnt_q;
        mem_wdata = CLEAR_VAL;
        clr_cnt_d = clr_cnt_q + AW'(1);
        if (clr_cnt_q == AW'(DEPTH - 1)) state_d = StReady;
      end
      StReady: mem_we = wr_ok;
      default: state_d = StClear;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StClear;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    phys = 2'd0;
    if (NUM_NT == 4) begin
      phys = req_nt;
    end else if (NUM_NT == 2) begin
      case (mirror)
        2'd0:    phys = {1'b0, req_nt[1]};
        2'd1:    phys = {1'b0, req_nt[0]};
        2'd2:    phys = 2'd0;
        default: phys = 2'd1;
      endcase
    end
  end

  assign rd_addr = AW'({phys, req_row[4:2], req_col[4:2]});
  assign sh      = {req_row[1], req_col[1], 1'b0};
  assign oor     = (req_row >= 5'd30);

`ifdef ATTR_BYPASS_EN
  logic [AW-1:0] addr1_q;
  always_ff @(posedge clk) addr1_q <= rd_addr;
`endif

  // Read-before-write: a same-edge write is not seen by this read.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
`ifdef ATTR_BYPASS_EN
    if (wr_ok && (wr_addr == rd_addr)) rd_byte_q <= wr_data;
    else                               rd_byte_q <= mem[rd_addr];
`else
    rd_byte_q <= mem[rd_addr];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) v1_q <= 1'b0;
    else     v1_q <= accept;
    sh1_q  <= sh;
    oor1_q <= oor;
  end

  always_comb begin
    byte1 = rd_byte_q;
`ifdef ATTR_BYPASS_EN
    if (wr_ok && (wr_addr == addr1_q)) byte1 = wr_data;
`endif
    pal_sel = oor1_q ? 2'b00 : byte1[sh1_q +: 2];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pal_valid_q <= 1'b0;
      pal_q       <= 2'b00;
      pal_byte_q  <= 8'h00;
    end else begin
      pal_valid_q <= v1_q;
      if (v1_q) begin
        pal_q      <= pal_sel;
        pal_byte_q <= byte1;
      end
    end
  end

  assign pal_valid = pal_valid_q;
  assign pal       = pal_q;
  assign pal_byte  = pal_byte_q;

endmodule

// File: tb/tb_attr_palette_lookup.sv
// Scoreboard bench for attr_palette_lookup (NUM_NT=2): clear, quadrants, mirroring, hazards, reset.
module tb_attr_palette_lookup;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] mirror;
  logic       wr_en;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_nt;
  logic [4:0] req_col;
  logic [4:0] req_row;
  logic       pal_valid;
  logic [1:0] pal;
  logic [7:0] pal_byte;
  logic       busy;

  attr_palette_lookup dut (
    .clk       (clk),
    .rst       (rst),
    .mirror    (mirror),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_nt    (req_nt),
    .req_col   (req_col),
    .req_row   (req_row),
    .pal_valid (pal_valid),
    .pal       (pal),
    .pal_byte  (pal_byte),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] pal;
    logic [7:0] b;
    int         cyc;
  } exp_t;

  exp_t       sb[$];
  exp_t       e;
  logic [7:0] model [128];
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (pal_valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: pal_valid=1 at cycle %0d, none expected", cyc);
      end else begin
        e = sb.pop_front();
        if (pal !== e.pal) begin
          errors++;
          $display("FAIL pal: got %0d expected %0d (cycle %0d)", pal, e.pal, cyc);
        end
        checks++;
        if (pal_byte !== e.b) begin
          errors++;
          $display("FAIL pal_byte: got %02h expected %02h (cycle %0d)", pal_byte, e.b, cyc);
        end
        checks++;
        if (cyc !== e.cyc) begin
          errors++;
          $display("FAIL latency: result at cycle %0d expected %0d", cyc, e.cyc);
        end
      end
    end
  end

  function automatic int addr_of(input logic [1:0] m, input logic [1:0] nt,
                                 input logic [4:0] col, input logic [4:0] row);
    int p;
    case (m)
      2'd0:    p = nt[1];
      2'd1:    p = nt[0];
      2'd2:    p = 0;
      default: p = 1;
    endcase
    return p * 64 + int'(row[4:2]) * 8 + int'(col[4:2]);
  endfunction

  function automatic logic [1:0] exp_pal(input logic [7:0] b, input logic [4:0] col,
                                         input logic [4:0] row);
    int s;
    if (row >= 5'd30) return 2'b00;
    s = (row[1] ? 4 : 0) + (col[1] ? 2 : 0);
    return 2'((b >> s) & 8'h03);
  endfunction

  task automatic wr(input int a, input logic [7:0] d);
    wr_en   = 1'b1;
    wr_addr = 7'(a);
    wr_data = d;
    model[a] = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic issue_exp(input logic [1:0] nt, input logic [4:0] col, input logic [4:0] row,
                           input logic [1:0] p, input logic [7:0] b);
    exp_t x;
    req_valid = 1'b1;
    req_nt    = nt;
    req_col   = col;
    req_row   = row;
    x.pal = p;
    x.b   = b;
    x.cyc = cyc + 2;
    sb.push_back(x);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic lookup(input logic [1:0] nt, input logic [4:0] col, input logic [4:0] row);
    logic [7:0] b;
    b = model[addr_of(mirror, nt, col, row)];
    issue_exp(nt, col, row, exp_pal(b, col, row), b);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  // Called at the negedge where rst has just been released.
  task automatic count_busy(input string tag);
    int n = 0;
    while (busy === 1'b1 && n < 1000) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != 128) begin
      errors++;
      $display("FAIL %s_busy_cycles: got %0d expected 128", tag, n);
    end
    for (int i = 0; i < 128; i++) model[i] = 8'h00;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 128; i++) wr(i, 8'($urandom_range(1, 255)));
    wr(0, 8'hE7);
    mirror = 2'd0;
    lookup(2'd0, 5'd0, 5'd0);
    drain();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1)      begin errors++; $display("FAIL rst_busy: got %b expected 1", busy); end
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b expected 0", req_ready); end
    checks++;
    if (pal_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", pal_valid); end
    checks++;
    if (pal !== 2'b00)      begin errors++; $display("FAIL rst_pal: got %0d expected 0", pal); end
    checks++;
    if (pal_byte !== 8'h00) begin errors++; $display("FAIL rst_byte: got %02h expected 00", pal_byte); end
    rst = 1'b0;
    count_busy("clear");
    mirror = 2'd1;
    for (int nt = 0; nt < 2; nt++)
      for (int r = 0; r < 32; r++)
        for (int c = 0; c < 32; c++)
          issue_exp(2'(nt), 5'(c), 5'(r), 2'b00, 8'h00);
    drain();
  endtask

  task automatic test_quadrant();
    mirror = 2'd0;
    wr(0, 8'hE4);
    issue_exp(2'd0, 5'd0, 5'd0, 2'd0, 8'hE4);
    issue_exp(2'd0, 5'd2, 5'd0, 2'd1, 8'hE4);
    issue_exp(2'd0, 5'd0, 5'd2, 2'd2, 8'hE4);
    issue_exp(2'd0, 5'd2, 5'd2, 2'd3, 8'hE4);
    drain();
  endtask

  task automatic test_mirror();
    wr(64 + 9, 8'h55);
    mirror = 2'd0;
    issue_exp(2'd2, 5'd4, 5'd4, 2'd1, 8'h55);
    issue_exp(2'd1, 5'd4, 5'd4, 2'd0, 8'h00);
    mirror = 2'd1;
    issue_exp(2'd1, 5'd4, 5'd4, 2'd1, 8'h55);
    mirror = 2'd3;
    issue_exp(2'd0, 5'd4, 5'd4, 2'd1, 8'h55);
    mirror = 2'd2;
    issue_exp(2'd3, 5'd4, 5'd4, 2'd0, 8'h00);
    drain();
  endtask

  task automatic test_row_range();
    mirror = 2'd0;
    wr(56, 8'hFF);
    issue_exp(2'd0, 5'd0, 5'd30, 2'd0, 8'hFF);
    issue_exp(2'd0, 5'd2, 5'd31, 2'd0, 8'hFF);
    issue_exp(2'd0, 5'd0, 5'd29, 2'd3, 8'hFF);
    drain();
  endtask

  task automatic test_hazard();
    logic [7:0] hb;
`ifdef ATTR_BYPASS_EN
    hb = 8'hAA;
`else
    hb = 8'h00;
`endif
    mirror = 2'd0;
    // Write in the accept cycle (offset 20 = row 8, col 16).
    wr_en = 1'b1; wr_addr = 7'd20; wr_data = 8'hAA;
    issue_exp(2'd0, 5'd16, 5'd8, (hb == 8'hAA) ? 2'd2 : 2'd0, hb);
    wr_en = 1'b0;
    model[20] = 8'hAA;
    issue_exp(2'd0, 5'd16, 5'd8, 2'd2, 8'hAA);
    drain();
    // Write one cycle after accept (offset 21 = row 8, col 20).
    issue_exp(2'd0, 5'd20, 5'd8, (hb == 8'hAA) ? 2'd2 : 2'd0, hb);
    wr(21, 8'hAA);
    drain();
    // Writes in both cycles: the later one wins under forwarding (offset 22 = row 8, col 24).
    wr_en = 1'b1; wr_addr = 7'd22; wr_data = 8'h11;
    issue_exp(2'd0, 5'd24, 5'd8, (hb == 8'hAA) ? 2'd2 : 2'd0, hb);
    wr(22, 8'hAA);
    drain();
    lookup(2'd0, 5'd24, 5'd8);
    drain();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 24; i++) wr(int'($urandom_range(0, 127)), 8'($urandom));
    for (int i = 0; i < 40; i++) begin
      mirror = 2'($urandom_range(0, 3));
      lookup(2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    end
    drain();
  endtask

  task automatic test_reset_mid();
    mirror = 2'd0;
    wr(3, 8'h3C);
    // Two unscored requests in flight, a write pending, then reset.
    req_valid = 1'b1; req_nt = 2'd0; req_col = 5'd0; req_row = 5'd0;
    @(negedge clk);
    req_col = 5'd4;
    rst = 1'b1;
    wr_en = 1'b1; wr_addr = 7'd3; wr_data = 8'h5A;
    @(negedge clk);
    req_valid = 1'b0;
    wr_en = 1'b0;
    checks++;
    if (pal_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b expected 0", pal_valid); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b expected 1", busy); end
    rst = 1'b0;
    count_busy("mid_lookup");
    issue_exp(2'd0, 5'd12, 5'd0, 2'd0, 8'h00);
    drain();
    // Reset partway through a clear restarts it from address 0.
    wr(100, 8'hC3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    count_busy("mid_clear");
    mirror = 2'd3;
    issue_exp(2'd0, 5'd0, 5'd12, 2'd0, 8'h00);
    drain();
  endtask

  initial begin
    rst = 1'b1; mirror = 2'd0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    req_valid = 1'b0; req_nt = '0; req_col = '0; req_row = '0;
    for (int i = 0; i < 128; i++) model[i] = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    count_busy("init");
    test_reset();
    test_quadrant();
    test_mirror();
    test_row_range();
    test_hazard();
    test_back_to_back();
    test_reset_mid();
    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
